// File: rtl/parity_pkg.sv
// Shared types and helpers for the even-parity generator/checker family.
package parity_pkg;

  // Receiver FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Widest data word the helper accepts; narrower words are zero-extended.
  localparam int unsigned MAX_PARITY_W = 32;

  // Even-parity bit for a data word: makes the total count of ones even.
  function automatic logic even_parity(input logic [MAX_PARITY_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/parity_accumulator.sv
// Running XOR of the serial bits of one frame.
module parity_accumulator (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic q
);

  // Clear wins over enable so a start bit always begins a fresh sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else if (clr) begin
      q <= 1'b0;
    end else if (en) begin
      q <= q ^ d;
    end
  end

endmodule

// File: rtl/even_parity_checker_rx.sv
// Serial receiver for start + DATA_W data (LSB first) + even parity + stop frames.
module even_parity_checker_rx
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_valid,
  input  logic                 rx_in,
  output logic [DATA_W-1:0]    data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  rx_state_t             state;
  logic [DATA_W-1:0]     shift_reg;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  par_q;
  logic                  par_clr;
  logic                  par_en;
  logic [ERR_CNT_W-1:0]  err_count_inc;

  // Parity sum restarts on a start bit and absorbs data and parity bits.
  assign par_clr = bit_valid && (state == IDLE) && (rx_in == START_BIT);
  assign par_en  = bit_valid && ((state == DATA) || (state == PARITY));

  parity_accumulator u_parity_acc (
    .clk (clk),
    .rst (rst),
    .clr (par_clr),
    .en  (par_en),
    .d   (rx_in),
    .q   (par_q)
  );

  // Error counter sticks at all-ones instead of wrapping.
  assign err_count_inc = (err_count == '1) ? err_count : err_count + ERR_CNT_W'(1);

  assign busy = (state != IDLE);

  // Frame FSM, deserialiser and registered result pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      err_count  <= '0;
    end else begin
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (bit_valid) begin
        unique case (state)
          IDLE: begin
            if (rx_in == START_BIT) begin
              shift_reg <= '0;
              bit_cnt   <= '0;
              state     <= DATA;
            end
          end
          DATA: begin
            shift_reg <= (shift_reg >> 1) | (DATA_W'(rx_in) << (DATA_W - 1));
            bit_cnt   <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (rx_in == STOP_BIT) begin
              if (!par_q) begin
                data_valid <= 1'b1;
                data_out   <= shift_reg;
              end else begin
                parity_err <= 1'b1;
                err_count  <= err_count_inc;
              end
            end else begin
              frame_err <= 1'b1;
              err_count <= err_count_inc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_even_parity_checker_rx.sv
// Randomised frame-level bench for even_parity_checker_rx with a frame-outcome model.
module tb_even_parity_checker_rx;

  localparam int unsigned DATA_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              bit_valid;
  logic              rx_in;
  logic [DATA_W-1:0] data_out,   data_out_s;
  logic              data_valid, data_valid_s;
  logic              parity_err, parity_err_s;
  logic              frame_err,  frame_err_s;
  logic              busy,       busy_s;
  logic [7:0]        err_count;
  logic [1:0]        err_count_s;

  even_parity_checker_rx #(.DATA_W(DATA_W), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .rx_in(rx_in),
    .data_out(data_out), .data_valid(data_valid), .parity_err(parity_err),
    .frame_err(frame_err), .busy(busy), .err_count(err_count)
  );

  // Narrow counter instance sharing the same serial stream, for saturation.
  even_parity_checker_rx #(.DATA_W(DATA_W), .ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .rx_in(rx_in),
    .data_out(data_out_s), .data_valid(data_valid_s), .parity_err(parity_err_s),
    .frame_err(frame_err_s), .busy(busy_s), .err_count(err_count_s)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected values at the next sampling point, and staged values for the one after.
  logic              exp_dv, exp_pe, exp_fe, exp_busy;
  logic [DATA_W-1:0] exp_data;
  int                exp_err, exp_err_s;
  logic              stg_dv, stg_pe, stg_fe, stg_busy;
  logic [DATA_W-1:0] stg_data;
  int                stg_err, stg_err_s;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic clear_model();
    exp_dv = 0; exp_pe = 0; exp_fe = 0; exp_busy = 0; exp_data = '0; exp_err = 0; exp_err_s = 0;
    stg_dv = 0; stg_pe = 0; stg_fe = 0; stg_busy = 0; stg_data = '0; stg_err = 0; stg_err_s = 0;
  endtask

  // One cycle: check outputs against the model, then drive the next serial input.
  task automatic tick(input logic v, input logic b);
    @(negedge clk);
    check("data_valid", 32'(data_valid), 32'(exp_dv));
    check("parity_err", 32'(parity_err), 32'(exp_pe));
    check("frame_err",  32'(frame_err),  32'(exp_fe));
    check("busy",       32'(busy),       32'(exp_busy));
    check("data_out",   32'(data_out),   32'(exp_data));
    check("err_count",  32'(err_count),  32'(exp_err));
    check("err_count_sat", 32'(err_count_s), 32'(exp_err_s));
    exp_dv = stg_dv; exp_pe = stg_pe; exp_fe = stg_fe; exp_busy = stg_busy;
    exp_data = stg_data; exp_err = stg_err; exp_err_s = stg_err_s;
    stg_dv = 0; stg_pe = 0; stg_fe = 0;
    bit_valid = v;
    rx_in = b;
  endtask

  task automatic gap(input int max_gap);
    if (max_gap > 0) begin
      repeat ($urandom_range(1, max_gap)) tick(1'b0, 1'($urandom));
    end
  endtask

  // Sends a whole frame; the model decides the outcome from the frame contents.
  task automatic send_frame(input logic [DATA_W-1:0] d, input logic par, input logic stop,
                            input int max_gap);
    int ones;
    stg_busy = 1;
    tick(1'b1, 1'b0);
    for (int i = 0; i < DATA_W; i++) begin
      gap(max_gap);
      tick(1'b1, d[i]);
    end
    gap(max_gap);
    tick(1'b1, par);
    gap(max_gap);
    ones = $countones(d) + int'(par);
    if (!stop) begin
      stg_fe = 1;
    end else if (ones % 2 != 0) begin
      stg_pe = 1;
    end else begin
      stg_dv = 1;
      stg_data = d;
    end
    if (stg_pe || stg_fe) begin
      stg_err   = (stg_err   < 255) ? stg_err + 1   : 255;
      stg_err_s = (stg_err_s < 3)   ? stg_err_s + 1 : 3;
    end
    stg_busy = 0;
    tick(1'b1, stop);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bit_valid = 1'b0;
    #1;
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_dv",    32'(data_valid), 32'd0);
    check("rst_pe",    32'(parity_err), 32'd0);
    check("rst_fe",    32'(frame_err),  32'd0);
    check("rst_data",  32'(data_out),   32'd0);
    check("rst_err",   32'(err_count),  32'd0);
    check("rst_err_s", 32'(err_count_s), 32'd0);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int sat_exp [5];
    sat_exp = '{1, 2, 3, 3, 3};
    clear_model();
    rst = 1'b1;
    bit_valid = 1'b0;
    rx_in = 1'b1;
    #12;
    check("init_busy", 32'(busy), 32'd0);
    check("init_data", 32'(data_out), 32'd0);
    check("init_err",  32'(err_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) tick(1'b1, 1'b1);

    // Good frame, then bad parity, then bad stop.
    send_frame(4'hB, 1'b1, 1'b1, 0);
    tick(1'b0, 1'b1);
    check("t1_data", 32'(data_out), 32'hB);
    check("t1_err",  32'(err_count), 32'd0);
    send_frame(4'hB, 1'b0, 1'b1, 0);
    tick(1'b0, 1'b1);
    check("t2_data", 32'(data_out), 32'hB);
    check("t2_err",  32'(err_count), 32'd1);
    send_frame(4'h5, 1'b0, 1'b0, 0);
    tick(1'b0, 1'b1);
    check("t3_err",  32'(err_count), 32'd2);
    check("t3_idle", 32'(busy), 32'd0);

    // Same good frame with idle gaps between bits.
    send_frame(4'hB, 1'b1, 1'b1, 3);
    tick(1'b0, 1'b1);

    // Reset in the middle of a frame, then a clean zero frame.
    stg_busy = 1;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    do_reset();
    send_frame(4'h0, 1'b0, 1'b1, 0);
    tick(1'b0, 1'b1);
    check("t5_data", 32'(data_out), 32'h0);

    // All data values back to back with correct parity.
    for (int v = 0; v < 16; v++) begin
      logic [DATA_W-1:0] dv;
      dv = DATA_W'(v);
      send_frame(dv, ^dv, 1'b1, 0);
    end
    tick(1'b0, 1'b1);
    check("t6_err", 32'(err_count), 32'd0);

    // Random frames, gaps and idle-line bits.
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) tick(1'b1, 1'b1);
      send_frame(DATA_W'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 3)));
    end
    tick(1'b0, 1'b1);

    // Saturation of the 2-bit counter.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      send_frame(4'h3, 1'b1, 1'b1, 0);
      tick(1'b0, 1'b1);
      check("t7_sat", 32'(err_count_s), 32'(sat_exp[k]));
    end
    repeat (2) tick(1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
